// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable wait
// states and an independent registered read-only observation port B.
// Optional feature macro: MEMRESP_BOUNDS_CHECK_EN (drives RespErr on
// out-of-range accesses; when undefined RespErr is tied low).
module mem_responder #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 200,
   parameter int WAIT_STATES = 2
) (
   input  logic              ExternalClk,
   input  logic              Reset,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [DATA_W-1:0] ReqData,
   output logic              RespValid,
   input  logic              RespReady,
   output logic [DATA_W-1:0] RespData,
   output logic              RespErr,
   input  logic [ADDR_W-1:0] AddrB,
   output logic [DATA_W-1:0] DoutB
);

   // One extra bit so DEPTH == 2^ADDR_W is representable.
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   logic w_accept;
   logic w_access;
   logic w_a_in_range;
   logic w_b_in_range;
   logic w_mem_we;

   assign w_accept     = (r_state == ST_IDLE) && ReqValid;
   assign w_access     = (r_state == ST_WAIT) && (r_cnt == 4'd0);
   assign w_a_in_range = ({1'b0, r_addr} < DEPTH_W);
   assign w_b_in_range = ({1'b0, AddrB} < DEPTH_W);
   assign w_mem_we     = w_access && r_write && w_a_in_range;

   // Request/response FSM with registered handshake and response outputs.
   always_ff @(posedge ExternalClk or posedge Reset) begin
      if (Reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_write   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         ReqReady  <= 1'b1;
         RespValid <= 1'b0;
         RespData  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (ReqValid) begin
                  r_write  <= ReqWrite;
                  r_addr   <= ReqAddr;
                  r_wdata  <= ReqData;
                  r_cnt    <= 4'(WAIT_STATES);
                  ReqReady <= 1'b0;
                  r_state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  RespValid <= 1'b1;
                  if (!w_a_in_range)
                     RespData <= '0;
                  else if (r_write)
                     RespData <= r_wdata;
                  else
                     RespData <= r_mem[r_addr];
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (RespReady) begin
                  RespValid <= 1'b0;
                  ReqReady  <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               RespValid <= 1'b0;
               ReqReady  <= 1'b1;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   // Memory write port; contents deliberately survive Reset.
   always_ff @(posedge ExternalClk) begin
      if (w_mem_we)
         r_mem[r_addr] <= r_wdata;
   end

   // Observation port: registered read, old data on a same-edge write.
   always_ff @(posedge ExternalClk or posedge Reset) begin
      if (Reset)
         DoutB <= '0;
      else if (w_b_in_range)
         DoutB <= r_mem[AddrB];
      else
         DoutB <= '0;
   end

`ifdef MEMRESP_BOUNDS_CHECK_EN
   logic r_err;

   // Error flag: set by an out-of-range access, cleared by the next acceptance.
   always_ff @(posedge ExternalClk or posedge Reset) begin
      if (Reset)
         r_err <= 1'b0;
      else if (w_accept)
         r_err <= 1'b0;
      else if (w_access)
         r_err <= !w_a_in_range;
   end

   assign RespErr = r_err;
`else
   assign RespErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed test-plan sequences plus
// randomized requests, all checked against an array-based memory model.
module tb_mem_responder;

   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 200;
   localparam int WS    = 2;

   logic          clk = 1'b0;
   logic          Reset;
   logic          ReqValid;
   logic          ReqReady;
   logic          ReqWrite;
   logic [AW-1:0] ReqAddr;
   logic [DW-1:0] ReqData;
   logic          RespValid;
   logic          RespReady;
   logic [DW-1:0] RespData;
   logic          RespErr;
   logic [AW-1:0] AddrB;
   logic [DW-1:0] DoutB;

   logic [DW-1:0] model [0:DEPTH-1];
   int            n_checks = 0;
   int            n_fail   = 0;
   bit            b_rand   = 1'b1;
   bit            exp_b_valid = 1'b0;
   logic [DW-1:0] exp_b;

   always #5 clk = ~clk;

   mem_responder #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(WS)
   ) dut (
      .ExternalClk(clk),
      .Reset(Reset),
      .ReqValid(ReqValid),
      .ReqReady(ReqReady),
      .ReqWrite(ReqWrite),
      .ReqAddr(ReqAddr),
      .ReqData(ReqData),
      .RespValid(RespValid),
      .RespReady(RespReady),
      .RespData(RespData),
      .RespErr(RespErr),
      .AddrB(AddrB),
      .DoutB(DoutB)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_err(input bit oor);
`ifdef MEMRESP_BOUNDS_CHECK_EN
      return oor;
`else
      return 1'b0 & oor;
`endif
   endfunction

   function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
      if (a < DEPTH) return model[a];
      return '0;
   endfunction

   // Port B scoreboard: expectation taken the negedge before each edge,
   // so a write on that edge is not yet visible (read-before-write).
   initial begin
      forever begin
         @(negedge clk);
         if (Reset) begin
            exp_b_valid = 1'b0;
         end else begin
            if (exp_b_valid) check_eq("doutb", DoutB, exp_b);
            if (b_rand) AddrB = AW'($urandom);
            exp_b = model_rd(AddrB);
            exp_b_valid = 1'b1;
         end
      end
   end

   // One complete transaction; must be called at a negedge.
   task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int hold, input bit chk_b);
      bit            in_r;
      logic [DW-1:0] exp_data;
      logic [DW-1:0] b_old;
      int            t;
      in_r     = (addr < DEPTH);
      b_old    = model_rd(addr);
      exp_data = !in_r ? '0 : (wr ? data : model_rd(addr));
      ReqValid = 1'b1; ReqWrite = wr; ReqAddr = addr; ReqData = data;
      t = 0;
      while (ReqReady !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (ReqReady !== 1'b1) begin
         check_eq("accept_timeout", 32'(ReqReady), 32'd1);
         ReqValid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      ReqValid = 1'b0; ReqWrite = 1'($urandom); ReqAddr = AW'($urandom); ReqData = DW'($urandom);
      for (int i = 0; i <= WS; i++) begin
         @(negedge clk);
         check_eq("wait_valid", 32'(RespValid), 32'd0);
         check_eq("wait_ready", 32'(ReqReady), 32'd0);
         RespReady = 1'($urandom);
         @(posedge clk);
      end
      #1;
      if (wr && in_r) model[addr] = data;
      @(negedge clk);
      $display("txn wr=%0d addr=%0d data=%h hold=%0d resp=%h err=%0d", wr, addr, data, hold, RespData, RespErr);
      check_eq("resp_valid", 32'(RespValid), 32'd1);
      check_eq("resp_data", 32'(RespData), 32'(exp_data));
      check_eq("resp_err", 32'(RespErr), 32'(exp_err(!in_r)));
      check_eq("resp_ready_low", 32'(ReqReady), 32'd0);
      if (chk_b) check_eq("b_old", 32'(DoutB), 32'(b_old));
      RespReady = (hold == 0);
      for (int i = 0; i < hold; i++) begin
         ReqValid = 1'b1; ReqWrite = 1'b1;
         ReqAddr = AW'($urandom_range(0, DEPTH-1)); ReqData = DW'($urandom);
         @(posedge clk);
         @(negedge clk);
         check_eq("hold_valid", 32'(RespValid), 32'd1);
         check_eq("hold_data", 32'(RespData), 32'(exp_data));
         check_eq("hold_err", 32'(RespErr), 32'(exp_err(!in_r)));
         check_eq("hold_ready", 32'(ReqReady), 32'd0);
         if (i == hold-1) begin
            ReqValid = 1'b0;
            RespReady = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_eq("done_valid", 32'(RespValid), 32'd0);
      check_eq("done_ready", 32'(ReqReady), 32'd1);
      if (chk_b) check_eq("b_new", 32'(DoutB), 32'((wr && in_r) ? data : b_old));
      RespReady = 1'($urandom);
   endtask

   // Write request interrupted by Reset in WAIT (in_resp=0) or RESP (in_resp=1).
   task automatic reset_mid(input bit in_resp, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int t;
      RespReady = 1'b0;
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = addr; ReqData = data;
      t = 0;
      while (ReqReady !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk); #1;
      ReqValid = 1'b0;
      if (!in_resp) begin
         @(posedge clk); #2;
      end else begin
         repeat (WS+1) @(posedge clk);
         #1;
         if (addr < DEPTH) model[addr] = data;
         #1;
         check_eq("pre_rst_valid", 32'(RespValid), 32'd1);
      end
      Reset = 1'b1;
      #1;
      $display("txn reset in_resp=%0d addr=%0d", in_resp, addr);
      check_eq("rst_ready", 32'(ReqReady), 32'd1);
      check_eq("rst_valid", 32'(RespValid), 32'd0);
      check_eq("rst_data", 32'(RespData), 32'd0);
      check_eq("rst_err", 32'(RespErr), 32'd0);
      check_eq("rst_doutb", 32'(DoutB), 32'd0);
      @(posedge clk); #2;
      Reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqData = '0;
      RespReady = 1'b0; AddrB = '0;
      repeat (2) @(negedge clk);
      check_eq("reset_ready", 32'(ReqReady), 32'd1);
      check_eq("reset_valid", 32'(RespValid), 32'd0);
      check_eq("reset_data", 32'(RespData), 32'd0);
      check_eq("reset_err", 32'(RespErr), 32'd0);
      check_eq("reset_doutb", 32'(DoutB), 32'd0);
      @(posedge clk); #2;
      Reset = 1'b0;
      @(negedge clk);

      // Bring every word to a known value through the normal write path.
      for (int a = 0; a < DEPTH; a++) do_req(1'b1, AW'(a), '0, 0, 1'b0);

      // Basic write, then observe it on port B.
      do_req(1'b1, 8'd5, 16'h1234, 0, 1'b0);
      @(posedge clk); #2;
      b_rand = 1'b0; AddrB = 8'd5;
      @(negedge clk);
      @(negedge clk);
      check_eq("b_addr5", 32'(DoutB), 32'h1234);
      b_rand = 1'b1;

      // Reads, backpressure, out-of-range.
      do_req(1'b0, 8'd5, 16'h0000, 0, 1'b0);
      do_req(1'b0, 8'd6, 16'h0000, 0, 1'b0);
      do_req(1'b0, 8'd5, 16'h0000, 5, 1'b0);
      do_req(1'b1, 8'd220, 16'hBEEF, 0, 1'b0);
      do_req(1'b0, 8'd220, 16'h0000, 0, 1'b0);
      do_req(1'b0, 8'd199, 16'h0000, 2, 1'b0);
      do_req(1'b1, 8'd200, 16'h0F0F, 1, 1'b0);

      // Reset in WAIT discards the write; reset in RESP keeps it.
      do_req(1'b1, 8'd9, 16'h0909, 0, 1'b0);
      reset_mid(1'b0, 8'd9, 16'hAAAA);
      do_req(1'b0, 8'd9, 16'h0000, 0, 1'b0);
      reset_mid(1'b1, 8'd12, 16'h7777);
      do_req(1'b0, 8'd12, 16'h0000, 0, 1'b0);

      // Port B collision on the access edge.
      do_req(1'b1, 8'd3, 16'h1111, 0, 1'b0);
      @(posedge clk); #2;
      b_rand = 1'b0; AddrB = 8'd3;
      @(negedge clk);
      do_req(1'b1, 8'd3, 16'h5555, 0, 1'b1);
      b_rand = 1'b1;

      // Randomized traffic.
      for (int n = 0; n < 150; n++)
         do_req(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 3)), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
